mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares the single off-chip SRAM port between instruction fetch (IF) and the MEM stage.
//  Sequences each multi-cycle SRAM access and returns read data with a one-cycle ack.
//  Drives stallreq_if / stallreq_mem into stall_ctrl while a requester is unserved.
// PARAMETERS
//  ADDR_W       20  SRAM word-address width; sram_addr = req_addr[ADDR_W+1:2]
//  DATA_W       32  data width
//  WAIT_CYCLES  2   cycles SRAM strobes are held per access; legal range 1..15
// PORTS
//  clk           in   1       system clock, rising edge
//  rst           in   1       asynchronous, active-high reset
//  if_req        in   1       IF read request, level, held until if_ack
//  if_addr       in   32      IF byte address
//  if_rdata      out  DATA_W  instruction word, valid when if_ack=1
//  if_ack        out  1       one-cycle completion pulse for IF
//  mem_req       in   1       MEM request, level, held until mem_ack
//  mem_we        in   1       1=write, 0=read
//  mem_addr      in   32      MEM byte address
//  mem_wdata     in   DATA_W  write data
//  mem_rdata     out  DATA_W  load data, valid when mem_ack=1
//  mem_ack       out  1       one-cycle completion pulse for MEM
//  stallreq_if   out  1       = if_req & ~if_ack (combinational)
//  stallreq_mem  out  1       = mem_req & ~mem_ack (combinational)
//  sram_addr     out  ADDR_W  SRAM word address
//  sram_wdata    out  DATA_W  SRAM write data
//  sram_rdata    in   DATA_W  SRAM read data
//  sram_ce_n     out  1       chip enable, active low
//  sram_oe_n     out  1       output enable, active low
//  sram_we_n     out  1       write enable, active low
// BEHAVIOUR
//  Reset: state=IDLE; cnt=0; sram_ce_n/oe_n/we_n=1; sram_addr, sram_wdata=0;
//   if_ack, mem_ack=0; if_rdata, mem_rdata=0; last_grant=IF.
//  FSM IDLE -> ACCESS -> DONE -> IDLE.
//   IDLE:   if any req: latch grant, addr, we, wdata; assert ce_n=0 and, for a read,
//           oe_n=0 or, for a write, we_n=0; cnt=WAIT_CYCLES-1; go ACCESS.
//   ACCESS: hold strobes and addr. If cnt==0: capture sram_rdata into granted rdata reg
//           (reads only), deassert all strobes, pulse granted ack, go DONE; else cnt--.
//   DONE:   ack low; 1-cycle bus turnaround; go IDLE. No new grant issued in DONE.
//  Latency: request seen in IDLE at edge N -> ack high in cycle N+WAIT_CYCLES.
//   Back-to-back issue interval is WAIT_CYCLES+2.
//  Priority: both reqs in IDLE -> MEM wins (older instruction); IF waits, stallreq_if stays 1.
//  The non-granted ack never pulses. rdata holds last value until next ack of that port.
//  Req dropped mid-access: access completes, ack still pulses, no abort.
//  Write: mem_rdata unchanged; mem_ack pulses.
//  rst asserted mid-access: immediate return to reset values, strobes deasserted
//   the same instant, no ack; the in-flight access is lost and the requester re-requests.
//  WAIT_CYCLES==1: ACCESS lasts exactly one cycle (cnt starts at 0).
// CONFIGURATION
//  ARB_FAIR_EN defined: round-robin on contention.
//   If both requesters are present in IDLE, grant the port not in last_grant.
//   last_grant updates on every grant.
//  ARB_FAIR_EN undefined: fixed MEM-over-IF priority; last_grant register absent.
// TESTING
//  1. Reset, then IF read 0x0000_0010 with sram_rdata=0x2402_0005, WAIT_CYCLES=2
//     -> sram_addr=0x4 and oe_n=0 for 2 cycles; if_ack 1 cycle with if_rdata=0x2402_0005.
//  2. MEM write addr 0x0000_0100, wdata 0xDEAD_BEEF -> sram_addr=0x40, we_n=0 2 cycles,
//     sram_wdata=0xDEAD_BEEF; mem_ack pulses; mem_rdata unchanged.
//  3. if_req and mem_req raised same cycle -> MEM served first, stallreq_if=1 throughout;
//     IF served next. ARB_FAIR_EN: second contention grants IF first.
//  4. rst pulsed during ACCESS -> strobes=1 immediately, no ack; after release, a re-request
//     completes normally.
//  5. Continuous if_req for 3 fetches -> if_ack every WAIT_CYCLES+2 cycles;
//     stallreq_if low only in ack cycles.
//  6. WAIT_CYCLES=1 build: single-cycle strobe; ack on next edge; mem_req dropped mid-access
//     still gets ack.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM port between instruction fetch and the MEM stage, one access at a time.
// Optional macro ARB_FAIR_EN: round-robin on contention instead of fixed MEM-over-IF priority.
module mem_bus_arbiter #(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [31:0]       mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ack,
  output logic              stallreq_if,
  output logic              stallreq_mem,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t            state, state_nx;
  logic [3:0]        cnt, cnt_nx;
  logic              grant_mem, grant_mem_nx;
  logic              we_q, we_nx;
  logic              pick_mem;
  logic              if_ack_nx, mem_ack_nx;
  logic [DATA_W-1:0] if_rdata_nx, mem_rdata_nx;
  logic [ADDR_W-1:0] sram_addr_nx;
  logic [DATA_W-1:0] sram_wdata_nx;
  logic              ce_n_nx, oe_n_nx, we_n_nx;

  // Byte-lane and upper address bits are not part of the SRAM word address.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[1:0], if_addr[31:ADDR_W+2],
                              mem_addr[1:0], mem_addr[31:ADDR_W+2]};

`ifdef ARB_FAIR_EN
  logic last_mem, last_mem_nx;
  // On contention the port that did not win last time goes first.
  assign pick_mem = mem_req & (~if_req | ~last_mem);
`else
  assign pick_mem = mem_req;
`endif

  assign stallreq_if  = if_req & ~if_ack;
  assign stallreq_mem = mem_req & ~mem_ack;

  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    grant_mem_nx  = grant_mem;
    we_nx         = we_q;
    if_ack_nx     = 1'b0;
    mem_ack_nx    = 1'b0;
    if_rdata_nx   = if_rdata;
    mem_rdata_nx  = mem_rdata;
    sram_addr_nx  = sram_addr;
    sram_wdata_nx = sram_wdata;
    ce_n_nx       = sram_ce_n;
    oe_n_nx       = sram_oe_n;
    we_n_nx       = sram_we_n;
`ifdef ARB_FAIR_EN
    last_mem_nx   = last_mem;
`endif
    case (state)
      IDLE: begin
        if (if_req | mem_req) begin
          grant_mem_nx = pick_mem;
          we_nx        = pick_mem & mem_we;
          sram_addr_nx = pick_mem ? mem_addr[ADDR_W+1:2] : if_addr[ADDR_W+1:2];
          if (pick_mem)
            sram_wdata_nx = mem_wdata;
          ce_n_nx  = 1'b0;
          oe_n_nx  = pick_mem & mem_we;
          we_n_nx  = ~(pick_mem & mem_we);
          cnt_nx   = CNT_INIT;
          state_nx = ACCESS;
`ifdef ARB_FAIR_EN
          last_mem_nx = pick_mem;
`endif
        end
      end
      ACCESS: begin
        // Strobes and address stay put until the wait count expires.
        if (cnt == 4'd0) begin
          if (!we_q) begin
            if (grant_mem)
              mem_rdata_nx = sram_rdata;
            else
              if_rdata_nx = sram_rdata;
          end
          ce_n_nx    = 1'b1;
          oe_n_nx    = 1'b1;
          we_n_nx    = 1'b1;
          mem_ack_nx = grant_mem;
          if_ack_nx  = ~grant_mem;
          state_nx   = DONE;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      grant_mem  <= 1'b0;
      we_q       <= 1'b0;
      if_ack     <= 1'b0;
      mem_ack    <= 1'b0;
      if_rdata   <= '0;
      mem_rdata  <= '0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
`ifdef ARB_FAIR_EN
      last_mem   <= 1'b0;
`endif
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      grant_mem  <= grant_mem_nx;
      we_q       <= we_nx;
      if_ack     <= if_ack_nx;
      mem_ack    <= mem_ack_nx;
      if_rdata   <= if_rdata_nx;
      mem_rdata  <= mem_rdata_nx;
      sram_addr  <= sram_addr_nx;
      sram_wdata <= sram_wdata_nx;
      sram_ce_n  <= ce_n_nx;
      sram_oe_n  <= oe_n_nx;
      sram_we_n  <= we_n_nx;
`ifdef ARB_FAIR_EN
      last_mem   <= last_mem_nx;
`endif
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a WAIT_CYCLES=2 instance plus a WAIT_CYCLES=1 instance.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        if_req = 1'b0, mem_req = 1'b0, mem_we = 1'b0;
  logic [31:0] if_addr = '0, mem_addr = '0, mem_wdata = '0, sram_rdata = '0;
  logic [31:0] if_rdata, mem_rdata, sram_wdata;
  logic        if_ack, mem_ack, stallreq_if, stallreq_mem;
  logic [19:0] sram_addr;
  logic        sram_ce_n, sram_oe_n, sram_we_n;

  logic        w1_if_req = 1'b0, w1_mem_req = 1'b0, w1_mem_we = 1'b0;
  logic [31:0] w1_if_addr = '0, w1_mem_addr = '0, w1_mem_wdata = '0, w1_sram_rdata = '0;
  logic [31:0] w1_if_rdata, w1_mem_rdata, w1_sram_wdata;
  logic        w1_if_ack, w1_mem_ack, w1_stallreq_if, w1_stallreq_mem;
  logic [19:0] w1_sram_addr;
  logic        w1_sram_ce_n, w1_sram_oe_n, w1_sram_we_n;

  int   total = 0;
  int   bad   = 0;
  logic last_mem_m = 1'b0;

  mem_bus_arbiter #(.ADDR_W(20), .DATA_W(32), .WAIT_CYCLES(2)) u0 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
  );

  mem_bus_arbiter #(.ADDR_W(20), .DATA_W(32), .WAIT_CYCLES(1)) u1 (
    .clk(clk), .rst(rst),
    .if_req(w1_if_req), .if_addr(w1_if_addr), .if_rdata(w1_if_rdata), .if_ack(w1_if_ack),
    .mem_req(w1_mem_req), .mem_we(w1_mem_we), .mem_addr(w1_mem_addr), .mem_wdata(w1_mem_wdata),
    .mem_rdata(w1_mem_rdata), .mem_ack(w1_mem_ack),
    .stallreq_if(w1_stallreq_if), .stallreq_mem(w1_stallreq_mem),
    .sram_addr(w1_sram_addr), .sram_wdata(w1_sram_wdata), .sram_rdata(w1_sram_rdata),
    .sram_ce_n(w1_sram_ce_n), .sram_oe_n(w1_sram_oe_n), .sram_we_n(w1_sram_we_n)
  );

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    total++; if (sram_ce_n !== 1'b1) begin bad++; $display("[TB] FAIL rst_ce_n got=%b want=1", sram_ce_n); end
    total++; if (sram_oe_n !== 1'b1) begin bad++; $display("[TB] FAIL rst_oe_n got=%b want=1", sram_oe_n); end
    total++; if (sram_we_n !== 1'b1) begin bad++; $display("[TB] FAIL rst_we_n got=%b want=1", sram_we_n); end
    total++; if (sram_addr !== 20'h0) begin bad++; $display("[TB] FAIL rst_addr got=%h want=0", sram_addr); end
    total++; if (sram_wdata !== 32'h0) begin bad++; $display("[TB] FAIL rst_wdata got=%h want=0", sram_wdata); end
    total++; if ({if_ack, mem_ack} !== 2'b00) begin bad++; $display("[TB] FAIL rst_acks got=%b want=00", {if_ack, mem_ack}); end
    total++; if (if_rdata !== 32'h0) begin bad++; $display("[TB] FAIL rst_if_rdata got=%h want=0", if_rdata); end
    total++; if (mem_rdata !== 32'h0) begin bad++; $display("[TB] FAIL rst_mem_rdata got=%h want=0", mem_rdata); end
    total++; if (w1_sram_ce_n !== 1'b1) begin bad++; $display("[TB] FAIL rst_w1_ce_n got=%b want=1", w1_sram_ce_n); end
    rst = 1'b0;
    last_mem_m = 1'b0;
  endtask

  task automatic test_if_read();
    if_req = 1'b1; if_addr = 32'h0000_0010; sram_rdata = 32'h2402_0005;
    step();
    total++; if (sram_addr !== 20'h4) begin bad++; $display("[TB] FAIL ifr_addr got=%h want=4", sram_addr); end
    total++; if ({sram_ce_n, sram_oe_n, sram_we_n} !== 3'b001) begin bad++; $display("[TB] FAIL ifr_strobe1 got=%b want=001", {sram_ce_n, sram_oe_n, sram_we_n}); end
    total++; if (stallreq_if !== 1'b1) begin bad++; $display("[TB] FAIL ifr_stall got=%b want=1", stallreq_if); end
    step();
    total++; if ({sram_oe_n, if_ack} !== 2'b00) begin bad++; $display("[TB] FAIL ifr_strobe2 got=%b want=00", {sram_oe_n, if_ack}); end
    step();
    total++; if (if_ack !== 1'b1) begin bad++; $display("[TB] FAIL ifr_ack got=%b want=1", if_ack); end
    total++; if (if_rdata !== 32'h2402_0005) begin bad++; $display("[TB] FAIL ifr_rdata got=%h want=24020005", if_rdata); end
    total++; if ({sram_ce_n, sram_oe_n} !== 2'b11) begin bad++; $display("[TB] FAIL ifr_release got=%b want=11", {sram_ce_n, sram_oe_n}); end
    total++; if ({stallreq_if, mem_ack} !== 2'b00) begin bad++; $display("[TB] FAIL ifr_stall_ack got=%b want=00", {stallreq_if, mem_ack}); end
    if_req = 1'b0;
    step();
    total++; if (if_ack !== 1'b0) begin bad++; $display("[TB] FAIL ifr_ack_pulse got=%b want=0", if_ack); end
    last_mem_m = 1'b0;
  endtask

  task automatic test_mem_write();
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h0000_0100; mem_wdata = 32'hDEAD_BEEF;
    step();
    total++; if (sram_addr !== 20'h40) begin bad++; $display("[TB] FAIL mw_addr got=%h want=40", sram_addr); end
    total++; if ({sram_ce_n, sram_oe_n, sram_we_n} !== 3'b010) begin bad++; $display("[TB] FAIL mw_strobe1 got=%b want=010", {sram_ce_n, sram_oe_n, sram_we_n}); end
    total++; if (sram_wdata !== 32'hDEAD_BEEF) begin bad++; $display("[TB] FAIL mw_wdata got=%h want=deadbeef", sram_wdata); end
    step();
    total++; if ({sram_we_n, mem_ack} !== 2'b00) begin bad++; $display("[TB] FAIL mw_strobe2 got=%b want=00", {sram_we_n, mem_ack}); end
    step();
    total++; if ({mem_ack, if_ack, sram_we_n} !== 3'b101) begin bad++; $display("[TB] FAIL mw_ack got=%b want=101", {mem_ack, if_ack, sram_we_n}); end
    total++; if (mem_rdata !== 32'h1111_1111) begin bad++; $display("[TB] FAIL mw_rdata_kept got=%h want=11111111", mem_rdata); end
    mem_req = 1'b0; mem_we = 1'b0;
    step();
    total++; if (mem_ack !== 1'b0) begin bad++; $display("[TB] FAIL mw_ack_pulse got=%b want=0", mem_ack); end
    last_mem_m = 1'b1;
  endtask

  task automatic test_contention(input logic [31:0] ia, input logic [31:0] ma,
                                 input logic [31:0] d1, input logic [31:0] d2);
    logic        first_mem;
    logic [19:0] wa_first, wa_second;
`ifdef ARB_FAIR_EN
    first_mem = ~last_mem_m;
`else
    first_mem = 1'b1;
`endif
    wa_first  = first_mem ? ma[21:2] : ia[21:2];
    wa_second = first_mem ? ia[21:2] : ma[21:2];
    if_req = 1'b1; if_addr = ia; mem_req = 1'b1; mem_we = 1'b0; mem_addr = ma; sram_rdata = d1;
    step();
    total++; if (sram_addr !== wa_first) begin bad++; $display("[TB] FAIL ct_first_addr got=%h want=%h", sram_addr, wa_first); end
    total++; if ({sram_oe_n, stallreq_if, stallreq_mem} !== 3'b011) begin bad++; $display("[TB] FAIL ct_first_strobe got=%b want=011", {sram_oe_n, stallreq_if, stallreq_mem}); end
    step(); step();
    total++; if ({mem_ack, if_ack} !== {first_mem, ~first_mem}) begin bad++; $display("[TB] FAIL ct_first_ack got=%b want=%b", {mem_ack, if_ack}, {first_mem, ~first_mem}); end
    total++; if ((first_mem ? mem_rdata : if_rdata) !== d1) begin bad++; $display("[TB] FAIL ct_first_rdata got=%h want=%h", (first_mem ? mem_rdata : if_rdata), d1); end
    total++; if ((first_mem ? stallreq_if : stallreq_mem) !== 1'b1) begin bad++; $display("[TB] FAIL ct_loser_stall got=0 want=1"); end
    if (first_mem) mem_req = 1'b0; else if_req = 1'b0;
    sram_rdata = d2;
    step();
    total++; if ({if_ack, mem_ack, sram_ce_n} !== 3'b001) begin bad++; $display("[TB] FAIL ct_done got=%b want=001", {if_ack, mem_ack, sram_ce_n}); end
    total++; if ((first_mem ? stallreq_if : stallreq_mem) !== 1'b1) begin bad++; $display("[TB] FAIL ct_done_stall got=0 want=1"); end
    step();
    total++; if (sram_addr !== wa_second) begin bad++; $display("[TB] FAIL ct_second_addr got=%h want=%h", sram_addr, wa_second); end
    total++; if (sram_oe_n !== 1'b0) begin bad++; $display("[TB] FAIL ct_second_oe got=%b want=0", sram_oe_n); end
    step(); step();
    total++; if ({mem_ack, if_ack} !== {~first_mem, first_mem}) begin bad++; $display("[TB] FAIL ct_second_ack got=%b want=%b", {mem_ack, if_ack}, {~first_mem, first_mem}); end
    total++; if ((first_mem ? if_rdata : mem_rdata) !== d2) begin bad++; $display("[TB] FAIL ct_second_rdata got=%h want=%h", (first_mem ? if_rdata : mem_rdata), d2); end
    if_req = 1'b0; mem_req = 1'b0;
    step();
    last_mem_m = ~first_mem;
  endtask

  task automatic test_reset_mid_access();
    if_req = 1'b1; if_addr = 32'h0000_0040; sram_rdata = 32'h7777_0000;
    step();
    total++; if (sram_ce_n !== 1'b0) begin bad++; $display("[TB] FAIL rma_started got=%b want=0", sram_ce_n); end
    #2 rst = 1'b1;
    #1;
    total++; if ({sram_ce_n, sram_oe_n, sram_we_n} !== 3'b111) begin bad++; $display("[TB] FAIL rma_strobes got=%b want=111", {sram_ce_n, sram_oe_n, sram_we_n}); end
    total++; if ({sram_addr, if_rdata} !== 52'h0) begin bad++; $display("[TB] FAIL rma_regs got=%h want=0", {sram_addr, if_rdata}); end
    total++; if (stallreq_if !== 1'b1) begin bad++; $display("[TB] FAIL rma_stall got=%b want=1", stallreq_if); end
    step();
    total++; if (if_ack !== 1'b0) begin bad++; $display("[TB] FAIL rma_no_ack got=%b want=0", if_ack); end
    rst = 1'b0;
    last_mem_m = 1'b0;
    step();
    total++; if ({sram_addr, sram_oe_n} !== {20'h10, 1'b0}) begin bad++; $display("[TB] FAIL rma_regrant got=%h want=%h", {sram_addr, sram_oe_n}, {20'h10, 1'b0}); end
    step(); step();
    total++; if ({if_ack, if_rdata} !== {1'b1, 32'h7777_0000}) begin bad++; $display("[TB] FAIL rma_complete got=%h want=%h", {if_ack, if_rdata}, {1'b1, 32'h7777_0000}); end
    if_req = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    logic exp_ack;
    if_req = 1'b1; if_addr = 32'h0000_0080;
    for (int k = 1; k <= 11; k++) begin
      sram_rdata = 32'hA000_0000 | 32'(k);
      step();
      exp_ack = ((k % 4) == 3);
      total++; if (if_ack !== exp_ack) begin bad++; $display("[TB] FAIL b2b_ack cyc=%0d got=%b want=%b", k, if_ack, exp_ack); end
      total++; if (stallreq_if !== ~exp_ack) begin bad++; $display("[TB] FAIL b2b_stall cyc=%0d got=%b want=%b", k, stallreq_if, ~exp_ack); end
      if (exp_ack) begin
        total++; if (if_rdata !== (32'hA000_0000 | 32'(k))) begin bad++; $display("[TB] FAIL b2b_rdata cyc=%0d got=%h want=%h", k, if_rdata, 32'hA000_0000 | 32'(k)); end
      end
    end
    if_req = 1'b0;
    step();
  endtask

  task automatic test_drop_mid_access();
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_0104; sram_rdata = 32'h0BAD_F00D;
    step();
    mem_req = 1'b0;
    #1;
    total++; if ({stallreq_mem, sram_addr} !== {1'b0, 20'h41}) begin bad++; $display("[TB] FAIL drop_state got=%h want=%h", {stallreq_mem, sram_addr}, {1'b0, 20'h41}); end
    step();
    total++; if ({mem_ack, sram_ce_n} !== 2'b00) begin bad++; $display("[TB] FAIL drop_hold got=%b want=00", {mem_ack, sram_ce_n}); end
    step();
    total++; if ({mem_ack, mem_rdata} !== {1'b1, 32'h0BAD_F00D}) begin bad++; $display("[TB] FAIL drop_ack got=%h want=%h", {mem_ack, mem_rdata}, {1'b1, 32'h0BAD_F00D}); end
    step();
    total++; if (mem_ack !== 1'b0) begin bad++; $display("[TB] FAIL drop_ack_pulse got=%b want=0", mem_ack); end
    last_mem_m = 1'b1;
  endtask

  task automatic test_wait_one();
    w1_mem_req = 1'b1; w1_mem_we = 1'b0; w1_mem_addr = 32'h0000_0044; w1_sram_rdata = 32'h5555_AAAA;
    step();
    total++; if ({w1_sram_ce_n, w1_sram_oe_n, w1_mem_ack} !== 3'b000) begin bad++; $display("[TB] FAIL w1_strobe got=%b want=000", {w1_sram_ce_n, w1_sram_oe_n, w1_mem_ack}); end
    total++; if (w1_sram_addr !== 20'h11) begin bad++; $display("[TB] FAIL w1_addr got=%h want=11", w1_sram_addr); end
    w1_mem_req = 1'b0;
    step();
    total++; if ({w1_mem_ack, w1_sram_oe_n} !== 2'b11) begin bad++; $display("[TB] FAIL w1_ack got=%b want=11", {w1_mem_ack, w1_sram_oe_n}); end
    total++; if (w1_mem_rdata !== 32'h5555_AAAA) begin bad++; $display("[TB] FAIL w1_rdata got=%h want=5555aaaa", w1_mem_rdata); end
    step();
    total++; if (w1_mem_ack !== 1'b0) begin bad++; $display("[TB] FAIL w1_ack_pulse got=%b want=0", w1_mem_ack); end
  endtask

  initial begin
    test_reset();
    test_if_read();
    test_contention(32'h0000_0020, 32'h0000_0200, 32'h1111_1111, 32'h2222_2222);
    test_mem_write();
    test_contention(32'h0000_0030, 32'h0000_0300, 32'h3333_3333, 32'h4444_4444);
    test_reset_mid_access();
    test_back_to_back();
    test_drop_mid_access();
    test_wait_one();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
